uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single uarttx transmitter among 4 byte-stream requesters.
It runs on the 16x baud clock from clkdiv and drives the transmitter's tx_data/tx_en while monitoring tx_status (1 = transmitter idle).
A requester keeps ownership of the transmitter until it sends a byte flagged last, so multi-byte packets are never interleaved.

Parameters:
BUSY_TIMEOUT, 32, cycles to wait for tx_status to fall after tx_en before declaring a missed start.
CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > BUSY_TIMEOUT.

Ports:
clk  in  1  16x baud clock; single clock domain.
reset  in  1  asynchronous, active-low reset.
req  in  4  per-requester "byte valid"; held until ack.
req_data  in  32  byte for requester i on bits [8i+7:8i].
req_last  in  4  per-requester flag: this byte ends the packet; sampled with req_data.
ack  out  4  one-cycle pulse; byte from requester i has been captured.
grant  out  4  one-hot owner of the transmitter; 0 when free.
busy  out  1  high whenever the state is not IDLE.
err_timeout  out  1  one-cycle pulse on a busy timeout.
tx_data  out  8  to uarttx.
tx_en  out  1  to uarttx; one-cycle start pulse.
tx_status  in  1  from uarttx; 1 = idle.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; grant, ack, tx_en, tx_data, err_timeout and busy all 0.
  - rr_ptr=0, last_r=0, counter=0.
  - Reset only clears tx_en; a frame already inside uarttx finishes on its own.
- All outputs are registered.
- States: IDLE, WAIT_BUSY, WAIT_IDLE, HOLD.
- IDLE:
  - Trigger: tx_status=1 and req!=0.
  - Winner w = first set bit of req, searched cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod 4).
  - At the next edge: grant<=onehot(w), tx_data<=req_data[w], last_r<=req_last[w], ack[w]<=1, tx_en<=1, counter<=0, state<=WAIT_BUSY.
  - If tx_status=0, requests wait and nothing changes.
- Capture edge (IDLE or HOLD):
  - ack and tx_en are high for exactly the one cycle after that edge.
  - tx_data stays stable until the next capture.
  - Latency is 1 cycle from a qualifying req to tx_en/ack.
- WAIT_BUSY:
  - The counter increments every cycle.
  - tx_status=0 -> WAIT_IDLE.
  - If the counter reaches BUSY_TIMEOUT with tx_status still 1: err_timeout pulses for 1 cycle, and the byte is treated as sent (same action as WAIT_IDLE completion below).
- WAIT_IDLE: on tx_status=1 the byte is complete.
  - If last_r=1: grant<=0, rr_ptr<=(w+1) mod 4, state<=IDLE.
  - Otherwise state<=HOLD and grant is kept.
- HOLD:
  - Only the granted requester is served; other req bits are ignored.
  - req[w]=1 (tx_status is 1 here) -> capture as in IDLE, then WAIT_BUSY.
  - The grant is held indefinitely until a byte with last=1 completes.
- Request handshake:
  - The requester drops req or presents the next byte in the cycle after ack.
  - A req still high at the next capture opportunity is treated as a new byte.
  - req_last is ignored except at capture.
- Simultaneous requests:
  - Only one winner per capture.
  - The round-robin pointer advances only at packet end, never per byte.
- The ack bit, tx_en and the capture happen on the same edge; no byte is ever acked without being sent.

Test Plan:
1. Single byte.
   - Stimulus: req=0001, data 0x41, last=1; tx_status model falls 2 cycles after tx_en and rises 160 cycles later.
   - Required: tx_en and ack[0] pulse 1 cycle after req, tx_data=0x41, grant=0001 until tx_status rises, then grant=0000 and busy=0.
2. Round-robin fairness.
   - Stimulus: req=1111 from reset, all last=1, each requester drops req after its ack.
   - Required: service order 0,1,2,3.
   - Follow-up: re-assert 1010 after rr_ptr=0 -> order 1,3; a following 0011 -> order 0,1.
3. Packet lock.
   - Stimulus: req1 sends 0x10, 0x11, 0x12 (last on 0x12); req2 asserted (0x55, last) from the first cycle.
   - Required: tx_data sequence 0x10, 0x11, 0x12, 0x55; grant stays 0010 through the packet, then 0100.
4. Busy timeout.
   - Stimulus: tx_status held at 1 after tx_en.
   - Required: err_timeout pulses BUSY_TIMEOUT cycles after tx_en; with last=1, grant clears and the next request is served.
5. Transmitter busy.
   - Stimulus: tx_status=0 while req=0100.
   - Required: no ack or tx_en until tx_status=1, then capture 1 cycle later.
6. Reset mid-packet.
   - Stimulus: reset=0 in HOLD for requester 2.
   - Required: grant=0, tx_en=0, busy=0 immediately without a clock edge; after release, req=1111 serves requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART TX arbiter.
// The arbiter uses the slave modport; requesters plus uarttx form the master side.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        err_timeout;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;

    modport master (
        output req, req_data, req_last, tx_status,
        input  ack, grant, busy, err_timeout, tx_data, tx_en
    );

    modport slave (
        input  req, req_data, req_last, tx_status,
        output ack, grant, busy, err_timeout, tx_data, tx_en
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uarttx among four byte requesters.
// All outputs are registered; ownership passes on only when a byte flagged last completes.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 32,
    parameter int CNT_W        = 6
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE, HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_rr_ptr, r_owner, w_rr_ptr_nxt, w_owner_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]         r_grant, r_ack, w_grant_nxt, w_ack_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_tx_en, r_err, r_busy, w_tx_en_nxt, w_err_nxt, w_busy_nxt;

    logic [1:0]         w_win, w_idx, w_cap_idx;
    logic               w_any, w_cap_idle, w_cap_hold, w_capture, w_timeout, w_done;

    // Scan offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        w_win = r_rr_ptr;
        w_any = 1'b0;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr_ptr + 2'(k);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_cap_idle = (r_state == IDLE) && bus.tx_status && w_any;
    assign w_cap_hold = (r_state == HOLD) && bus.tx_status && bus.req[r_owner];
    assign w_capture  = w_cap_idle || w_cap_hold;
    assign w_cap_idx  = w_cap_idle ? w_win : r_owner;
    // Timeout fires on the edge where the counter would reach BUSY_TIMEOUT.
    assign w_timeout  = (r_state == WAIT_BUSY) && bus.tx_status &&
                        (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));
    assign w_done     = ((r_state == WAIT_IDLE) && bus.tx_status) || w_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_cap_idle) w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!bus.tx_status) w_state_nxt = WAIT_IDLE;
                       else if (w_timeout) w_state_nxt = r_last ? IDLE : HOLD;
            WAIT_IDLE: if (bus.tx_status) w_state_nxt = r_last ? IDLE : HOLD;
            HOLD:      if (w_cap_hold) w_state_nxt = WAIT_BUSY;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt   = r_grant;
        w_ack_nxt     = 4'b0000;
        w_tx_en_nxt   = 1'b0;
        w_err_nxt     = w_timeout;
        w_tx_data_nxt = r_tx_data;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cnt_nxt     = (r_state == WAIT_BUSY) ? r_cnt + CNT_W'(1) : r_cnt;
        w_busy_nxt    = (w_state_nxt != IDLE);
        if (w_capture) begin
            w_grant_nxt   = 4'b0001 << w_cap_idx;
            w_ack_nxt     = 4'b0001 << w_cap_idx;
            w_tx_en_nxt   = 1'b1;
            w_tx_data_nxt = bus.req_data[{w_cap_idx, 3'b000} +: 8];
            w_last_nxt    = bus.req_last[w_cap_idx];
            w_owner_nxt   = w_cap_idx;
            w_cnt_nxt     = '0;
        end
        if (w_done && r_last) begin
            w_grant_nxt  = 4'b0000;
            w_rr_ptr_nxt = r_owner + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant   <= 4'b0000;
            r_ack     <= 4'b0000;
            r_tx_en   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_data <= 8'h00;
            r_last    <= 1'b0;
            r_owner   <= 2'd0;
            r_rr_ptr  <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_tx_en   <= w_tx_en_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.ack         = r_ack;
    assign bus.tx_en       = r_tx_en;
    assign bus.err_timeout = r_err;
    assign bus.busy        = r_busy;
    assign bus.tx_data     = r_tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive req, a uarttx model drives
// tx_status, and a monitor pops expected captures on every tx_en.
module tb_uart_tx_arbiter;
    localparam int TMO   = 32;
    localparam int FRAME = 160;

    typedef struct { logic [7:0] d; logic l; } item_t;
    typedef struct { int idx; logic [7:0] d; int lat; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  tb_req = 4'b0;
    logic [31:0] tb_data = 32'h0;
    logic [3:0]  tb_last = 4'b0;
    logic        m_status = 1'b1;
    logic        force_busy = 1'b0;
    bit          respond = 1'b1;
    int          m_cnt = 0;
    int          cyc = 0;
    int          req_cyc [4];
    int          n_checks = 0;
    int          n_errors = 0;
    item_t       rq [4][$];
    exp_t        exp_q [$];
    exp_t        mon_e;

    uart_tx_arbiter_if bus ();

    assign bus.req       = tb_req;
    assign bus.req_data  = tb_data;
    assign bus.req_last  = tb_last;
    assign bus.tx_status = m_status && !force_busy;

    uart_tx_arbiter #(.BUSY_TIMEOUT(TMO), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic req_byte(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d; it.l = l;
        rq[i].push_back(it);
    endtask

    task automatic exp_byte(input int i, input logic [7:0] d, input int lat);
        exp_t e;
        e.idx = i; e.d = d; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int bound, input string nm);
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < bound) begin
            @(negedge clk); #1;
            n++;
            ok = !bus.busy && tb_req == 4'b0 && exp_q.size() == 0 &&
                 rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
        end
        check(nm, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Requesters: present the queue head, advance on ack.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) tb_req[i] = 1'b0;
            else begin
                if (tb_req[i] && bus.ack[i]) begin
                    if (rq[i].size() > 0) rq[i].delete(0);
                    tb_req[i] = 1'b0;
                end
                if (!tb_req[i] && rq[i].size() > 0) begin
                    tb_req[i]         = 1'b1;
                    tb_data[8*i +: 8] = rq[i][0].d;
                    tb_last[i]        = rq[i][0].l;
                    req_cyc[i]        = cyc;
                end
            end
        end
    end

    // uarttx model: goes busy 2 cycles after tx_en, idle again FRAME cycles later.
    initial forever begin
        @(negedge clk);
        if (m_cnt > 0) begin
            m_cnt++;
            if (m_cnt == 3) m_status = 1'b0;
            else if (m_cnt == 3 + FRAME) begin
                m_status = 1'b1;
                m_cnt = 0;
            end
        end else if (bus.tx_en && respond) m_cnt = 1;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && (bus.tx_en || bus.ack != 4'b0)) begin
            check("ack_with_tx_en", 32'(bus.ack != 4'b0), 32'(bus.tx_en));
            if (bus.tx_en) begin
                if (exp_q.size() == 0) check("unexpected_tx_en", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", 32'(bus.tx_data), 32'(mon_e.d));
                    check("ack", 32'(bus.ack), 32'd1 << mon_e.idx);
                    check("grant", 32'(bus.grant), 32'd1 << mon_e.idx);
                    if (mon_e.lat >= 0) check("latency", cyc - req_cyc[mon_e.idx], mon_e.lat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, t0;
        bit seen;

        #12;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. single byte
        req_byte(0, 8'h41, 1'b1); exp_byte(0, 8'h41, 1);
        n = 0;
        while (bus.tx_status && n < 20) begin @(negedge clk); #1; n++; end
        check("s1_status_fall", 32'(bus.tx_status), 32'd0);
        n = 0;
        while (!bus.tx_status && n < FRAME + 20) begin @(negedge clk); #1; n++; end
        check("s1_grant_held", 32'(bus.grant), 32'b0001);
        check("s1_busy_held", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("s1_grant_clr", 32'(bus.grant), 32'd0);
        check("s1_busy_clr", 32'(bus.busy), 32'd0);
        wait_done(20, "s1_done");

        // 2. round robin from reset, then 1010 and 0011
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_byte(i, 8'h20 + 8'(i), 1'b1);
            exp_byte(i, 8'h20 + 8'(i), -1);
        end
        wait_done(4 * (FRAME + 20), "s2_rr_done");
        req_byte(1, 8'h31, 1'b1); req_byte(3, 8'h33, 1'b1);
        exp_byte(1, 8'h31, -1);   exp_byte(3, 8'h33, -1);
        wait_done(2 * (FRAME + 20), "s2_1010_done");
        req_byte(0, 8'h40, 1'b1); req_byte(1, 8'h41, 1'b1);
        exp_byte(0, 8'h40, -1);   exp_byte(1, 8'h41, -1);
        wait_done(2 * (FRAME + 20), "s2_0011_done");

        // 3. packet lock
        do_reset();
        req_byte(1, 8'h10, 1'b0); req_byte(1, 8'h11, 1'b0); req_byte(1, 8'h12, 1'b1);
        req_byte(2, 8'h55, 1'b1);
        exp_byte(1, 8'h10, -1); exp_byte(1, 8'h11, -1); exp_byte(1, 8'h12, -1);
        exp_byte(2, 8'h55, -1);
        wait_done(4 * (FRAME + 20), "s3_done");

        // 4. busy timeout; rr_ptr is now 3, so requester 3 goes first
        respond = 1'b0;
        req_byte(0, 8'h77, 1'b1); req_byte(3, 8'h78, 1'b1);
        exp_byte(3, 8'h78, -1);   exp_byte(0, 8'h77, -1);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin @(negedge clk); #1; n++; seen = bus.tx_en; end
        t0 = cyc;
        n = 0; seen = 1'b0;
        while (!seen && n < TMO + 20) begin @(negedge clk); #1; n++; seen = bus.err_timeout; end
        check("s4_err_seen", 32'(seen), 32'd1);
        check("s4_err_delay", cyc - t0, TMO);
        check("s4_grant_clr", 32'(bus.grant), 32'd0);
        @(negedge clk); #1;
        check("s4_err_pulse", 32'(bus.err_timeout), 32'd0);
        wait_done(2 * TMO + 40, "s4_done");
        respond = 1'b1;

        // 5. transmitter busy holds off capture
        force_busy = 1'b1;
        req_byte(2, 8'h99, 1'b1); exp_byte(2, 8'h99, -1);
        n = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (bus.tx_en || bus.ack != 4'b0) n++;
        end
        check("s5_no_capture", n, 0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        t0 = cyc;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin @(negedge clk); #1; n++; seen = bus.tx_en; end
        check("s5_capture_delay", cyc - t0, 1);
        wait_done(FRAME + 40, "s5_done");

        // 6. reset while holding for requester 2
        req_byte(2, 8'hA0, 1'b0); exp_byte(2, 8'hA0, -1);
        n = 0;
        while (bus.tx_status && n < 20) begin @(negedge clk); #1; n++; end
        n = 0;
        while (!bus.tx_status && n < FRAME + 20) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        #1;
        check("s6_hold_grant", 32'(bus.grant), 32'b0100);
        check("s6_hold_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_grant", 32'(bus.grant), 32'd0);
        check("s6_rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("s6_rst_busy", 32'(bus.busy), 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_byte(i, 8'hB0 + 8'(i), 1'b1);
            exp_byte(i, 8'hB0 + 8'(i), -1);
        end
        wait_done(4 * (FRAME + 20), "s6_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
